// File: rtl/fir_to_audio_bridge.sv
// Stereo FIR -> audio DAC stream bridge: scale/saturate, error substitution, prefill-gated FIFOs.
// Define FIR_BRIDGE_STATUS_CNT_EN to implement the drop_count/err_count status counters.
module fir_to_audio_bridge #(
  parameter int unsigned DEPTH   = 8,
  parameter int unsigned PREFILL = 4,
  parameter int unsigned SHIFT   = 8,
  parameter int unsigned OUT_W   = 24
) (
  input  logic        clk_clk,
  input  logic        reset_reset,
  input  logic [31:0] fir_left_output_data,
  input  logic        fir_left_output_valid,
  input  logic [1:0]  fir_left_output_error,
  input  logic [31:0] fir_right_output_data,
  input  logic        fir_right_output_valid,
  input  logic [1:0]  fir_right_output_error,
  output logic [31:0] left_input_data,
  output logic        left_input_valid,
  input  logic        left_input_ready,
  output logic [31:0] right_input_data,
  output logic        right_input_valid,
  input  logic        right_input_ready,
  output logic [1:0]  overflow_flag,
  output logic [1:0]  underrun_flag,
  output logic [15:0] drop_count,
  output logic [15:0] err_count
);
  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = AW + 1;
  localparam logic [CW-1:0] DepthC   = CW'(DEPTH);
  localparam logic [CW-1:0] PrefillC = CW'(PREFILL);
  localparam logic signed [31:0] SatMax = 32'sh7FFF_FFFF >>> (32 - OUT_W);
  localparam logic signed [31:0] SatMin = 32'sh8000_0000 >>> (32 - OUT_W);

  typedef enum logic {StPrime, StRun} state_e;

  logic [31:0]        in_data [2];
  logic [1:0]         in_err [2];
  logic [1:0]         in_valid, out_ready, out_valid;
  logic [1:0]         s1_valid_q, s1_valid_d;
  logic [31:0]        s1_data_q [2], s1_data_d [2];
  logic [31:0]        last_good_q [2], last_good_d [2];
  logic [AW-1:0]      wptr_q [2], wptr_d [2], rptr_q [2], rptr_d [2];
  logic [CW-1:0]      count_q [2], count_d [2];
  state_e             state_q [2], state_d [2];
  logic [1:0]         overflow_q, overflow_d, underrun_q, underrun_d;
  logic [31:0]        mem_q [2][DEPTH];
  logic [1:0]         accept, pop, drop, err_hit;
  logic signed [31:0] shifted [2], clamped [2];

  assign in_data[0] = fir_left_output_data;
  assign in_data[1] = fir_right_output_data;
  assign in_err[0]  = fir_left_output_error;
  assign in_err[1]  = fir_right_output_error;
  assign in_valid   = {fir_right_output_valid, fir_left_output_valid};
  assign out_ready  = {right_input_ready, left_input_ready};

  always_comb begin
    for (int c = 0; c < 2; c++) begin
      shifted[c] = $signed(in_data[c]) >>> SHIFT;
      if (shifted[c] > SatMax) begin
        clamped[c] = SatMax;
      end else if (shifted[c] < SatMin) begin
        clamped[c] = SatMin;
      end else begin
        clamped[c] = shifted[c];
      end
      err_hit[c]     = in_valid[c] && (in_err[c] != 2'b00);
      s1_valid_d[c]  = in_valid[c];
      s1_data_d[c]   = err_hit[c] ? last_good_q[c] : clamped[c];
      last_good_d[c] = (in_valid[c] && !err_hit[c]) ? clamped[c] : last_good_q[c];

      out_valid[c] = (state_q[c] == StRun) && (count_q[c] != '0);
      pop[c]       = out_valid[c] && out_ready[c];
      // A full FIFO still takes the write when the head leaves on the same edge.
      accept[c]    = s1_valid_q[c] && ((count_q[c] < DepthC) || pop[c]);
      drop[c]      = s1_valid_q[c] && !accept[c];
      wptr_d[c]    = accept[c] ? wptr_q[c] + AW'(1) : wptr_q[c];
      rptr_d[c]    = pop[c] ? rptr_q[c] + AW'(1) : rptr_q[c];
      count_d[c]   = count_q[c] + CW'(accept[c]) - CW'(pop[c]);
      overflow_d[c] = overflow_q[c] | drop[c];

      state_d[c]    = state_q[c];
      underrun_d[c] = underrun_q[c];
      unique case (state_q[c])
        StPrime: if (count_d[c] >= PrefillC) state_d[c] = StRun;
        StRun: begin
          if ((count_q[c] == '0) && !accept[c]) begin
            state_d[c]    = StPrime;
            underrun_d[c] = 1'b1;
          end
        end
        default: state_d[c] = StPrime;
      endcase
    end
  end

  always_ff @(posedge clk_clk) begin
    if (reset_reset) begin
      s1_valid_q <= '0;
      overflow_q <= '0;
      underrun_q <= '0;
      for (int c = 0; c < 2; c++) begin
        s1_data_q[c]   <= '0;
        last_good_q[c] <= '0;
        wptr_q[c]      <= '0;
        rptr_q[c]      <= '0;
        count_q[c]     <= '0;
        state_q[c]     <= StPrime;
        for (int i = 0; i < int'(DEPTH); i++) mem_q[c][i] <= '0;
      end
    end else begin
      s1_valid_q <= s1_valid_d;
      overflow_q <= overflow_d;
      underrun_q <= underrun_d;
      for (int c = 0; c < 2; c++) begin
        s1_data_q[c]   <= s1_data_d[c];
        last_good_q[c] <= last_good_d[c];
        wptr_q[c]      <= wptr_d[c];
        rptr_q[c]      <= rptr_d[c];
        count_q[c]     <= count_d[c];
        state_q[c]     <= state_d[c];
        if (accept[c]) mem_q[c][wptr_q[c]] <= s1_data_q[c];
      end
    end
  end

  assign left_input_data   = mem_q[0][rptr_q[0]];
  assign right_input_data  = mem_q[1][rptr_q[1]];
  assign left_input_valid  = out_valid[0];
  assign right_input_valid = out_valid[1];
  assign overflow_flag     = overflow_q;
  assign underrun_flag     = underrun_q;

`ifdef FIR_BRIDGE_STATUS_CNT_EN
  logic [15:0] drop_count_q, drop_count_d, err_count_q, err_count_d;
  logic [16:0] drop_sum, err_sum;

  always_comb begin
    drop_sum     = {1'b0, drop_count_q} + 17'(drop[0]) + 17'(drop[1]);
    err_sum      = {1'b0, err_count_q} + 17'(err_hit[0]) + 17'(err_hit[1]);
    drop_count_d = drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
    err_count_d  = err_sum[16] ? 16'hFFFF : err_sum[15:0];
  end

  always_ff @(posedge clk_clk) begin
    if (reset_reset) begin
      drop_count_q <= '0;
      err_count_q  <= '0;
    end else begin
      drop_count_q <= drop_count_d;
      err_count_q  <= err_count_d;
    end
  end

  assign drop_count = drop_count_q;
  assign err_count  = err_count_q;
`else
  assign drop_count = 16'h0000;
  assign err_count  = 16'h0000;
`endif

endmodule

// File: tb/tb_fir_to_audio_bridge.sv
// Scoreboard bench for fir_to_audio_bridge; a second SHIFT=4 instance covers saturation.
module tb_fir_to_audio_bridge;
`ifdef FIR_BRIDGE_STATUS_CNT_EN
  localparam bit CntEn = 1'b1;
`else
  localparam bit CntEn = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] l_d, r_d, s_d;
  logic        l_v, r_v, s_v;
  logic [1:0]  l_e, r_e, s_e;
  logic        l_ready, r_ready;
  logic [31:0] ld, rd, sd, s_rd;
  logic        lv, rv, sv, s_rv;
  logic [1:0]  ovf, unr, s_ovf, s_unr;
  logic [15:0] dcnt, ecnt, s_dc, s_ec;

  int checks = 0;
  int errors = 0;
  logic [31:0] exp_l[$], exp_r[$], exp_s[$];
  logic [31:0] lg [3];

  always #5 clk = ~clk;

  fir_to_audio_bridge u_dut (
    .clk_clk(clk), .reset_reset(rst),
    .fir_left_output_data(l_d), .fir_left_output_valid(l_v), .fir_left_output_error(l_e),
    .fir_right_output_data(r_d), .fir_right_output_valid(r_v), .fir_right_output_error(r_e),
    .left_input_data(ld), .left_input_valid(lv), .left_input_ready(l_ready),
    .right_input_data(rd), .right_input_valid(rv), .right_input_ready(r_ready),
    .overflow_flag(ovf), .underrun_flag(unr), .drop_count(dcnt), .err_count(ecnt)
  );

  fir_to_audio_bridge #(.SHIFT(4)) u_sat (
    .clk_clk(clk), .reset_reset(rst),
    .fir_left_output_data(s_d), .fir_left_output_valid(s_v), .fir_left_output_error(s_e),
    .fir_right_output_data(32'h0), .fir_right_output_valid(1'b0),
    .fir_right_output_error(2'b00),
    .left_input_data(sd), .left_input_valid(sv), .left_input_ready(1'b1),
    .right_input_data(s_rd), .right_input_valid(s_rv), .right_input_ready(1'b1),
    .overflow_flag(s_ovf), .underrun_flag(s_unr), .drop_count(s_dc), .err_count(s_ec)
  );

  function automatic logic [31:0] scale(input logic [31:0] d, input int sh);
    longint v;
    v = longint'($signed(d)) >>> sh;
    if (v > 64'sd8388607) v = 64'sd8388607;
    else if (v < -64'sd8388608) v = -64'sd8388608;
    return v[31:0];
  endfunction

  function automatic int qsize(input int ch);
    if (ch == 0) return exp_l.size();
    if (ch == 1) return exp_r.size();
    return exp_s.size();
  endfunction

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // One-cycle strobe; the model value is queued only if the bench expects it to be kept.
  task automatic drive(input int ch, input logic [31:0] d, input logic [1:0] e, input bit keep);
    logic [31:0] v;
    v = (e != 2'b00) ? lg[ch] : scale(d, (ch == 2) ? 4 : 8);
    if (e == 2'b00) lg[ch] = v;
    if (keep) begin
      if (ch == 0) exp_l.push_back(v);
      else if (ch == 1) exp_r.push_back(v);
      else exp_s.push_back(v);
    end
    if (ch == 0) begin l_d = d; l_e = e; l_v = 1'b1; end
    else if (ch == 1) begin r_d = d; r_e = e; r_v = 1'b1; end
    else begin s_d = d; s_e = e; s_v = 1'b1; end
    tick(1);
    l_v = 1'b0; r_v = 1'b0; s_v = 1'b0;
    l_e = 2'b00; r_e = 2'b00; s_e = 2'b00;
  endtask

  task automatic clear_model();
    exp_l.delete(); exp_r.delete(); exp_s.delete();
    for (int i = 0; i < 3; i++) lg[i] = '0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    l_v = 1'b0; r_v = 1'b0; s_v = 1'b0;
    l_e = 2'b00; r_e = 2'b00; s_e = 2'b00;
    l_d = '0; r_d = '0; s_d = '0;
    l_ready = 1'b0; r_ready = 1'b0;
    clear_model();
    tick(2);
    rst = 1'b0;
  endtask

  task automatic wait_drain(input int ch, input int limit);
    int n;
    n = 0;
    while (qsize(ch) != 0 && n < limit) begin
      tick(1);
      n++;
    end
    checks++;
    if (qsize(ch) != 0) begin
      errors++;
      $display("FAIL drain_ch%0d: %0d samples still pending, required 0", ch, qsize(ch));
    end
  endtask

  // Scoreboard: every handshake pops the oldest expected sample of that stream.
  always @(negedge clk) begin : monitor
    logic [31:0] e;
    if (!rst) begin
      if (lv && l_ready) begin
        checks++;
        if (exp_l.size() == 0) begin
          errors++; $display("FAIL left_unexpected: got %h, required no output", ld);
        end else begin
          e = exp_l.pop_front();
          if (ld !== e) begin errors++; $display("FAIL left_data: got %h, required %h", ld, e); end
        end
      end
      if (rv && r_ready) begin
        checks++;
        if (exp_r.size() == 0) begin
          errors++; $display("FAIL right_unexpected: got %h, required no output", rd);
        end else begin
          e = exp_r.pop_front();
          if (rd !== e) begin errors++; $display("FAIL right_data: got %h, required %h", rd, e); end
        end
      end
      if (sv) begin
        checks++;
        if (exp_s.size() == 0) begin
          errors++; $display("FAIL sat_unexpected: got %h, required no output", sd);
        end else begin
          e = exp_s.pop_front();
          if (sd !== e) begin errors++; $display("FAIL sat_data: got %h, required %h", sd, e); end
        end
      end
    end
  end

  task automatic test_reset();
    do_reset();
    checks += 8;
    if (lv !== 1'b0) begin errors++; $display("FAIL reset_lvalid: got %b, required 0", lv); end
    if (rv !== 1'b0) begin errors++; $display("FAIL reset_rvalid: got %b, required 0", rv); end
    if (ld !== 32'h0) begin errors++; $display("FAIL reset_ldata: got %h, required 0", ld); end
    if (rd !== 32'h0) begin errors++; $display("FAIL reset_rdata: got %h, required 0", rd); end
    if (ovf !== 2'b00) begin errors++; $display("FAIL reset_ovf: got %b, required 00", ovf); end
    if (unr !== 2'b00) begin errors++; $display("FAIL reset_unr: got %b, required 00", unr); end
    if (dcnt !== 16'h0) begin errors++; $display("FAIL reset_dcnt: got %h, required 0", dcnt); end
    if (ecnt !== 16'h0) begin errors++; $display("FAIL reset_ecnt: got %h, required 0", ecnt); end
  endtask

  task automatic test_prime();
    logic [31:0] vals [4];
    vals = '{32'h0000_1200, 32'h0000_2400, 32'h0000_3600, 32'h0000_4800};
    do_reset();
    l_ready = 1'b1; r_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      drive(0, vals[i], 2'b00, 1'b1);
      checks++;
      if (lv !== 1'b0) begin errors++; $display("FAIL prime_lvalid%0d: got %b, required 0", i, lv); end
      if (i < 3) begin
        for (int k = 0; k < 3; k++) begin
          tick(1);
          checks++;
          if (lv !== 1'b0) begin
            errors++; $display("FAIL prime_hold%0d: got %b, required 0", i, lv);
          end
        end
      end
    end
    wait_drain(0, 20);
    tick(3);
    checks += 3;
    if (lv !== 1'b0) begin errors++; $display("FAIL prime_after_lvalid: got %b, required 0", lv); end
    if (rv !== 1'b0) begin errors++; $display("FAIL prime_rvalid: got %b, required 0", rv); end
    if (unr !== 2'b01) begin errors++; $display("FAIL prime_unr: got %b, required 01", unr); end
  endtask

  task automatic test_saturation();
    do_reset();
    drive(2, 32'h7FFF_FFFF, 2'b00, 1'b1);
    drive(2, 32'h8000_0000, 2'b00, 1'b1);
    drive(2, 32'h0000_0100, 2'b00, 1'b1);
    drive(2, 32'h0001_2345, 2'b00, 1'b1);
    checks++;
    if (exp_s[0] !== 32'h007F_FFFF || exp_s[1] !== 32'hFF80_0000 || exp_s[2] !== 32'h0000_0010) begin
      errors++; $display("FAIL sat_model: got %h %h %h", exp_s[0], exp_s[1], exp_s[2]);
    end
    wait_drain(2, 20);
  endtask

  task automatic test_error();
    do_reset();
    l_ready = 1'b1;
    drive(0, 32'h0001_0000, 2'b00, 1'b1);
    drive(0, 32'h7777_7777, 2'b01, 1'b1);
    drive(0, 32'h0000_0200, 2'b00, 1'b1);
    drive(0, 32'h0000_0300, 2'b00, 1'b1);
    wait_drain(0, 20);
    checks++;
    if (ecnt !== (CntEn ? 16'd1 : 16'd0)) begin
      errors++; $display("FAIL err_count: got %0d, required %0d", ecnt, CntEn ? 1 : 0);
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    r_ready = 1'b1;
    for (int i = 0; i < 6; i++) drive(1, 32'h0000_0100 * (i + 3) + 32'hFFF0_0000, 2'b00, 1'b1);
    wait_drain(1, 20);
    tick(3);
    checks += 2;
    if (lv !== 1'b0) begin errors++; $display("FAIL b2b_lvalid: got %b, required 0", lv); end
    if (unr !== 2'b10) begin errors++; $display("FAIL b2b_unr: got %b, required 10", unr); end
  endtask

  task automatic test_overflow();
    do_reset();
    for (int i = 0; i < 10; i++) drive(0, 32'h0010_0000 * (i + 1), 2'b00, i < 8);
    tick(3);
    checks += 5;
    if (ovf !== 2'b01) begin errors++; $display("FAIL ovf_flag: got %b, required 01", ovf); end
    if (dcnt !== (CntEn ? 16'd2 : 16'd0)) begin
      errors++; $display("FAIL ovf_dcnt: got %0d, required %0d", dcnt, CntEn ? 2 : 0);
    end
    if (lv !== 1'b1) begin errors++; $display("FAIL ovf_valid: got %b, required 1", lv); end
    if (ld !== exp_l[0]) begin errors++; $display("FAIL ovf_head: got %h, required %h", ld, exp_l[0]); end
    tick(2);
    if (ld !== exp_l[0]) begin errors++; $display("FAIL ovf_stable: got %h, required %h", ld, exp_l[0]); end
    l_ready = 1'b1;
    wait_drain(0, 30);
    tick(3);
    checks += 2;
    if (unr !== 2'b01) begin errors++; $display("FAIL ovf_unr: got %b, required 01", unr); end
    if (lv !== 1'b0) begin errors++; $display("FAIL ovf_empty_valid: got %b, required 0", lv); end
    for (int i = 0; i < 3; i++) begin
      drive(0, 32'h0000_0500 + i, 2'b00, 1'b1);
      tick(2);
      checks++;
      if (lv !== 1'b0) begin errors++; $display("FAIL reprime%0d: got %b, required 0", i, lv); end
    end
    drive(0, 32'h0000_0900, 2'b00, 1'b1);
    wait_drain(0, 20);
  endtask

  task automatic test_full_pop();
    do_reset();
    for (int i = 0; i < 8; i++) drive(0, 32'h0000_1000 * (i + 1), 2'b00, 1'b1);
    tick(3);
    drive(0, 32'h0000_A000, 2'b00, 1'b1);
    l_ready = 1'b1;
    tick(1);
    l_ready = 1'b0;
    tick(2);
    checks += 2;
    if (ovf !== 2'b00) begin errors++; $display("FAIL full_pop_ovf: got %b, required 00", ovf); end
    if (dcnt !== 16'd0) begin errors++; $display("FAIL full_pop_dcnt: got %0d, required 0", dcnt); end
    drive(0, 32'h0000_B000, 2'b00, 1'b0);
    tick(3);
    checks += 2;
    if (ovf !== 2'b01) begin errors++; $display("FAIL full_drop_ovf: got %b, required 01", ovf); end
    if (dcnt !== (CntEn ? 16'd1 : 16'd0)) begin
      errors++; $display("FAIL full_drop_dcnt: got %0d, required %0d", dcnt, CntEn ? 1 : 0);
    end
    l_ready = 1'b1;
    wait_drain(0, 30);
  endtask

  task automatic test_reset_mid();
    do_reset();
    drive(0, 32'h0003_0000, 2'b00, 1'b1);
    drive(0, 32'h0000_0000, 2'b11, 1'b1);
    for (int i = 0; i < 3; i++) drive(0, 32'h0004_0000 + 32'h100 * i, 2'b00, 1'b1);
    tick(3);
    checks++;
    if (lv !== 1'b1) begin errors++; $display("FAIL mid_valid_before: got %b, required 1", lv); end
    drive(0, 32'h0ABC_0000, 2'b00, 1'b0);
    rst = 1'b1;
    clear_model();
    tick(1);
    rst = 1'b0;
    checks += 6;
    if (lv !== 1'b0) begin errors++; $display("FAIL mid_valid: got %b, required 0", lv); end
    if (ld !== 32'h0) begin errors++; $display("FAIL mid_data: got %h, required 0", ld); end
    if (ovf !== 2'b00) begin errors++; $display("FAIL mid_ovf: got %b, required 00", ovf); end
    if (unr !== 2'b00) begin errors++; $display("FAIL mid_unr: got %b, required 00", unr); end
    if (dcnt !== 16'h0) begin errors++; $display("FAIL mid_dcnt: got %h, required 0", dcnt); end
    if (ecnt !== 16'h0) begin errors++; $display("FAIL mid_ecnt: got %h, required 0", ecnt); end
    tick(4);
    checks++;
    if (lv !== 1'b0) begin errors++; $display("FAIL mid_inflight: got %b, required 0", lv); end
    l_ready = 1'b1;
    drive(0, 32'h1234_5678, 2'b10, 1'b1);
    for (int i = 0; i < 3; i++) drive(0, 32'h0006_0000 + 32'h100 * i, 2'b00, 1'b1);
    wait_drain(0, 20);
    checks++;
    if (ecnt !== (CntEn ? 16'd1 : 16'd0)) begin
      errors++; $display("FAIL mid_ecnt_after: got %0d, required %0d", ecnt, CntEn ? 1 : 0);
    end
  endtask

  initial begin
    test_reset();
    test_prime();
    test_saturation();
    test_error();
    test_back_to_back();
    test_overflow();
    test_full_pop();
    test_reset_mid();
    tick(2);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, required completion");
    $fatal(1, "watchdog expired");
  end
endmodule
